// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size encodings and helpers for the load/store unit
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    // True when the access does not sit on its natural boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane merge and load extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              zero_ext,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] loaded
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Replace the addressed lane(s) of the fetched word with the store data
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Pick the addressed lane(s) and extend to a full word
    always_comb begin
        byte_val = word[{offset, 3'b000} +: 8];
        half_val = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: loaded = zero_ext ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: loaded = zero_ext ? {16'h0000, half_val}   : {{16{half_val[15]}}, half_val};
            default: loaded = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer to word memory; option macro LSU_MISALIGN_TRAP_EN
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_t state, next_state;

    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              req_err;
    logic [1:0]        req_off;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] loaded;

    logic              mem_read_d;
    logic              mem_write_d;
    logic [WORD_W-1:0] mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_d;
    logic              resp_valid_d;
    logic              resp_err_d;
    logic [WORD_W-1:0] resp_rdata_d;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Classify the request and normalise the lane offset; aligned requests are unaffected
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0]);
`else
        req_err = (req_size == 2'b11);
`endif
        case (req_size)
            SZ_HALF: req_off = {req_addr[1], 1'b0};
            SZ_WORD: req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
    end

    // Capture the accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_off;
            wdata_q <= req_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                 next_state = RESP;
                    else if (!req_we)            next_state = READ;
                    else if (req_size == SZ_WORD) next_state = WRITE;
                    else                         next_state = READ;
                end
            end
            READ:    next_state = we_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    lsu_align u_align (
        .word     (mem_rdata),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (off_q),
        .zero_ext (uns_q),
        .merged   (merged),
        .loaded   (loaded)
    );

    // Output decode: values the registered outputs take on entering the next state.
    // The fetched word is consumed straight from mem_rdata at the READ edge, so the
    // merged store word and extended load data are latched in the output registers.
    always_comb begin
        mem_read_d   = (next_state == READ);
        mem_write_d  = (next_state == WRITE);
        resp_valid_d = (next_state == RESP);
        resp_err_d   = accept && req_err;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if (accept && !req_err) begin
            mem_addr_d = {req_addr[WORD_W-1:2], 2'b00};
            if (req_we && (req_size == SZ_WORD)) mem_wdata_d = req_wdata;
        end
        if (state == READ) begin
            if (we_q) mem_wdata_d  = merged;
            else      resp_rdata_d = loaded;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    int errors = 0;
    int checks = 0;

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_saw_rd;
    logic        r_saw_wr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write)   mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_we) mem[pre_addr[7:2]] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = 0; r_rdata = 'x; r_err = 1'bx;
        r_saw_rd = 1'b0; r_saw_wr = 1'b0; r_wr_addr = '0; r_wr_data = '0;
        for (int i = 1; i <= 10; i++) begin
            if (mem_read) r_saw_rd = 1'b1;
            if (mem_write) begin
                r_saw_wr = 1'b1; r_wr_addr = mem_addr; r_wr_data = mem_wdata;
            end
            if (resp_valid) begin
                r_lat = i; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] exp);
        do_req(1'b0, sz, uns, a, 32'h0);
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_lat"}, r_lat, 2);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b1;

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        check("sw_lat", r_lat, 2);
        check("sw_no_read", r_saw_rd, 0);
        check("sw_wrote", r_saw_wr, 1);
        check("sw_addr", r_wr_addr, 32'h40);
        check("sw_wdata", r_wr_data, 32'hDEADBEEF);
        check("sw_err", r_err, 0);
        check("sw_rdata", r_rdata, 0);
        @(negedge clk);
        check("sw_mem", mem[16], 32'hDEADBEEF);
        load_chk("lw40", 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        check("lw40_no_write", r_saw_wr, 0);

        // Sub-word stores with read-modify-write
        preload(32'h10, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
        check("sb_lat", r_lat, 3);
        check("sb_read", r_saw_rd, 1);
        check("sb_addr", r_wr_addr, 32'h10);
        check("sb_wdata", r_wr_data, 32'h11AA3344);
        preload(32'h30, 32'hAAAAAAAA);
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF1234);
        check("sh_lat", r_lat, 3);
        check("sh_wdata", r_wr_data, 32'h1234AAAA);

        // Load extraction and extension
        preload(32'h20, 32'h80FF7F01);
        load_chk("lb22", 2'b00, 1'b0, 32'h22, 32'hFFFFFFFF);
        load_chk("lbu22", 2'b00, 1'b1, 32'h22, 32'h000000FF);
        load_chk("lb20", 2'b00, 1'b0, 32'h20, 32'h00000001);
        load_chk("lh20", 2'b01, 1'b0, 32'h20, 32'h00007F01);
        load_chk("lh22", 2'b01, 1'b0, 32'h22, 32'hFFFF80FF);
        load_chk("lhu22", 2'b01, 1'b1, 32'h22, 32'h000080FF);

        // Misaligned accesses
        do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw21_err", r_err, 1);
        check("lw21_rdata", r_rdata, 0);
        check("lw21_lat", r_lat, 1);
        check("lw21_no_read", r_saw_rd, 0);
        check("lw21_no_write", r_saw_wr, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        check("lh23_err", r_err, 1);
        check("lh23_lat", r_lat, 1);
`else
        check("lw21_err", r_err, 0);
        check("lw21_rdata", r_rdata, 32'h80FF7F01);
        check("lw21_lat", r_lat, 2);
        check("lw21_read", r_saw_rd, 1);
        do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        check("lh23_err", r_err, 0);
        check("lh23_rdata", r_rdata, 32'hFFFF80FF);
`endif

        // Illegal size
        do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        check("sz3_ld_err", r_err, 1);
        check("sz3_ld_rdata", r_rdata, 0);
        check("sz3_ld_lat", r_lat, 1);
        check("sz3_ld_no_read", r_saw_rd, 0);
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678);
        check("sz3_st_err", r_err, 1);
        check("sz3_st_no_write", r_saw_wr, 0);
        check("sz3_st_lat", r_lat, 1);

        // Reset asserted during WRITE of a half store
        preload(32'h30, 32'h55667788);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_in_write", mem_write, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_mem_write", mem_write, 0);
        check("mid_mem_read", mem_read, 0);
        check("mid_mem_addr", mem_addr, 0);
        check("mid_mem_wdata", mem_wdata, 0);
        check("mid_resp_valid", resp_valid, 0);
        check("mid_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("mid_mem_kept", mem[12], 32'h55667788);
        check("mid_ready_after", req_ready, 1);
        load_chk("lw30_after", 2'b10, 1'b0, 32'h30, 32'h55667788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the execute stage and the word-addressed data memory. Accepts one load or store per handshake, converts byte/halfword/word RISC-V accesses into whole-word memory operations, and performs read-modify-write for sub-word stores. Extracts and sign/zero-extends load data and flags misaligned accesses. Downstream it drives the data memory's MemRead/MemWrite/address/write-data lines, which take a byte address and index by `addr>>2`.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; 1 only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size; valid with resp_valid.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  32  `{addr[31:2],2'b00}`.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On `req_valid && req_ready`, register we/size/unsigned/addr/wdata, then branch:
  - error: to RESP with err=1.
  - load: to READ.
  - word store: to WRITE.
  - byte/half store: to READ.
- READ: mem_read=1. Capture mem_rdata into a word register at the clock edge. Next state is WRITE for a store, RESP for a load.
- WRITE: mem_write=1. mem_wdata is:
  - word store: req_wdata.
  - sub-word store: the captured word with the selected lane(s) replaced.
  - Lane selection: byte lane = addr[1:0]; half lane = addr[1].
  - Next state RESP.
- RESP: resp_valid=1, then return to IDLE.
- Load extraction:
  - byte: bits `[8*addr[1:0]+:8]`.
  - half: bits `[16*addr[1]+:16]`.
  - Sign-extend unless req_unsigned.
- Error conditions: half with addr[0]=1; word with addr[1:0]≠0; size 11. An error request causes no memory access; resp_rdata=0.
- mem_read and mem_write are never both 1. mem_addr is held stable through READ→WRITE.

## Timing
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- Reset asserted mid-operation abandons the access. No write is issued after reset is asserted.
- Latency from accept edge to resp_valid:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- The memory write commits on the clock edge ending WRITE.
- Back-to-back: the next request can be accepted in the cycle after RESP. No overlap.
- resp_* outputs are registered. The memory-side outputs are a registered decode of the state.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: misaligned half/word requests produce resp_err=1 with no access, as described above.
- Undefined:
  - Misaligned requests proceed with the offending low address bits forced to 0 (half ignores addr[0]; word ignores addr[1:0]).
  - resp_err is asserted only for size 11.

## Structure
- Package `lsu_pkg`:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum (IDLE/READ/WRITE/RESP);
  - WORD_W=32.
- Sub-module `lsu_align`: purely combinational lane merge (store) and extract/extend (load). The FSM stays in the top module.

## Test plan
- Word store 0xDEADBEEF @0x40, then word load @0x40 -> mem_write one cycle with mem_addr=0x40; load resp_rdata=0xDEADBEEF after 2 cycles.
- Memory word 0x11223344 @0x10; SB 0xAA @0x12 -> READ then WRITE with mem_wdata=0x11AA3344; resp 3 cycles after accept.
- Word 0x80FF7F01 @0x20: LB @0x22 -> 0xFFFFFFFF; LBU @0x22 -> 0x000000FF; LH @0x20 -> 0x00007F01; LH @0x22 -> 0xFFFF80FF.
- LW @0x21 with macro defined -> resp_err=1, resp_rdata=0, mem_read/mem_write never asserted, latency 1. Without macro -> reads @0x20, err=0.
- Reset driven low during WRITE of SH @0x30 -> outputs return to reset values immediately; memory word unchanged; req_ready=1 after release.
- size=11 request -> err=1 in both configurations; no memory activity.
